mul_div_unit: RTL and testbench

//   Execute-stage multiply/divide unit. Holds the HI/LO registers and runs

---
 rtl/muldiv_pkg.sv | 47 ++++
 rtl/muldiv_core.sv | 50 +++++
 rtl/mul_div_unit.sv | 88 ++++++++
 tb/tb_mul_div_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Op codes, FSM states and op-class helpers for the execute-stage mul/div unit.
// MULDIV_MADD_EN enables the madd/maddu/msub/msubu accumulate ops.
package muldiv_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MFLO  = 4'd7;
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } mdreq_t;

    // Ops that occupy the unit for MULT_LAT cycles.
    function automatic logic is_mult_op(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational 64-bit {hi,lo} result from latched operands; wr=0 suppresses
// the HI/LO update (divide by zero).
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] acc,
    output logic [63:0] result,
    output logic        wr
);

    logic [63:0] sprod, uprod;
    logic [31:0] abs_a, abs_b, uq, ur, sq, sr, udq, udr;
    logic        b_zero;

    // Low 64 bits of the sign-extended product equal the signed product.
    assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign uprod = {32'd0, a} * {32'd0, b};

    assign b_zero = (b == 32'd0);

    // Signed divide via magnitudes; 0x80000000/-1 falls out as q=0x80000000, r=0.
    assign abs_a = a[31] ? -a : a;
    assign abs_b = b[31] ? -b : b;
    assign uq    = b_zero ? 32'd0 : abs_a / abs_b;
    assign ur    = b_zero ? 32'd0 : abs_a % abs_b;
    assign sq    = (a[31] ^ b[31]) ? -uq : uq;
    assign sr    = a[31] ? -ur : ur;
    assign udq   = b_zero ? 32'd0 : a / b;
    assign udr   = b_zero ? 32'd0 : a % b;

    always_comb begin
        result = '0;
        wr     = 1'b0;
        case (op)
            OP_MULT:  begin result = sprod;       wr = 1'b1;    end
            OP_MULTU: begin result = uprod;       wr = 1'b1;    end
            OP_DIV:   begin result = {sr, sq};    wr = !b_zero; end
            OP_DIVU:  begin result = {udr, udq};  wr = !b_zero; end
            OP_MADD:  begin result = acc + sprod; wr = 1'b1;    end
            OP_MADDU: begin result = acc + uprod; wr = 1'b1;    end
            OP_MSUB:  begin result = acc - sprod; wr = 1'b1;    end
            OP_MSUBU: begin result = acc - uprod; wr = 1'b1;    end
            default:  begin result = '0;          wr = 1'b0;    end
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit: HI/LO registers, IDLE/RUN FSM with a
// fixed-latency down-counter. Accumulate ops exist only with MULDIV_MADD_EN.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] out
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    mdreq_t        req_q;
    logic          idle_start, accept_mul, accept_div, accept, done;
    logic [63:0]   core_res;
    logic          core_wr;

    // A start while busy is dropped here, independent of the hazard unit.
    assign idle_start = start && (state == S_IDLE);
    assign accept_mul = idle_start && is_mult_op(op);
    assign accept_div = idle_start && is_div_op(op);
    assign accept     = accept_mul || accept_div;
    assign done       = (state == S_RUN) && (cnt == CW'(1));

    assign busy = (state == S_RUN);
    assign out  = (op == OP_MFHI) ? hi : lo;

    muldiv_core u_core (
        .op     (req_q.op),
        .a      (req_q.a),
        .b      (req_q.b),
        .acc    ({hi, lo}),
        .result (core_res),
        .wr     (core_wr)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RUN;
            S_RUN:   if (done)   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            req_q <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (accept) begin
                req_q <= '{op: op, a: rs_val, b: rt_val};
                cnt   <= accept_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
            end else if (state == S_RUN) begin
                cnt <= cnt - CW'(1);
            end

            if (done && core_wr) begin
                {hi, lo} <= core_res;
            end else if (idle_start && op == OP_MTHI) begin
                hi <= rs_val;
            end else if (idle_start && op == OP_MTLO) begin
                lo <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO/latency queued at issue,
// checked by a monitor on each busy falling edge.
module tb_mul_div_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = OP_MFLO;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy;
    logic [31:0] hi, lo, out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    mul_div_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .out    (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: count busy cycles, compare at each completion.
    logic prev_busy = 1'b0;
    int   run_len = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            run_len = 0;
        end else begin
            if (busy) run_len++;
            if (prev_busy && !busy) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_completion", 32'(run_len), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_hi", hi, e.hi);
                    chk("done_lo", lo, e.lo);
                    chk("busy_cycles", 32'(run_len), 32'(e.lat));
                end
                run_len = 0;
            end
        end
        prev_busy = busy;
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        // Scramble operands to show they were latched.
        start = 1'b0; op = OP_MFLO; rs_val = 32'hA5A5A5A5; rt_val = 32'h5A5A5A5A;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            errors++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n);
        end
        @(posedge clk); #1;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL missing_completion: %0d results pending, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int lat);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.lat = lat;
        sbq.push_back(e);
        issue(o, a, b);
        wait_idle();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_out", out, 32'd0);
        reset = 1'b0;

        // mult / multu
        run_op(OP_MULT,  32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 5);
        op = OP_MFHI; #1;
        chk("mfhi_out", out, 32'hFFFFFFFF);
        op = OP_MFLO; #1;
        chk("mflo_out", out, 32'hFFFFFFEB);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
        run_op(OP_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);

        // div / divu, including divide-by-zero and overflow corner
        run_op(OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        run_op(OP_DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
        run_op(OP_DIVU, 32'hFFFFFFFF, 32'd16, 32'h0000000F, 32'h0FFFFFFF, 10);
        run_op(OP_DIV,  32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10);

        // start while busy is ignored
        begin
            exp_t e;
            e.hi = 32'd2; e.lo = 32'd14; e.lat = 10;
            sbq.push_back(e);
        end
        issue(OP_DIV, 32'd100, 32'd7);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            start = 1'b1; op = OP_MTLO; rs_val = 32'h0000DEAD;
        end
        start = 1'b0; op = OP_MFLO;
        wait_idle();

        issue(OP_MTHI, 32'h00001234, 32'd0);
        chk("mthi_hi", hi, 32'h00001234);
        chk("mthi_lo_kept", lo, 32'd14);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        issue(OP_MTLO, 32'h00000055, 32'd0);
        chk("mtlo_lo", lo, 32'h00000055);

        // illegal op
        issue(4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (3) @(posedge clk); #1;
        chk("illegal_busy", {31'd0, busy}, 32'd0);
        chk("illegal_hi", hi, 32'h00001234);
        chk("illegal_lo", lo, 32'h00000055);

        // reset mid-divide aborts
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (2) @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        reset = 1'b0;
        repeat (14) @(posedge clk); #1;
        chk("abort_hi_later", hi, 32'd0);
        chk("abort_lo_later", lo, 32'd0);
        chk("abort_busy_later", {31'd0, busy}, 32'd0);

        // accumulate ops
        issue(OP_MTLO, 32'd10, 32'd0);
        issue(OP_MTHI, 32'd0, 32'd0);
`ifdef MULDIV_MADD_EN
        run_op(OP_MADD, 32'd3, 32'd4, 32'd0, 32'd22, 5);
        run_op(OP_MSUB, 32'd2, 32'd3, 32'd0, 32'd16, 5);
`else
        issue(OP_MADD, 32'd3, 32'd4);
        repeat (8) @(posedge clk); #1;
        chk("madd_off_busy", {31'd0, busy}, 32'd0);
        chk("madd_off_lo", lo, 32'd10);
        chk("madd_off_hi", hi, 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
